// File: rtl/guess_engine.sv
// Number-guessing game core: secret capture, guess comparison, attempt accounting and IDLE/PLAY/WIN/LOSE control.
// Optional range hints (lo_bound/hi_bound narrowing) are built only when RANGE_HINT_EN is defined.
module guess_engine #(
    parameter int W          = 17,
    parameter int SECRET_MAX = 99999,
    parameter int TRY_W      = 4,
    parameter int MAX_TRIES  = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             secret_load,
    input  logic             new_game,
    input  logic             guess_valid,
    input  logic [W-1:0]     value_in,
    input  logic [TRY_W-1:0] tries_limit,
    output logic [1:0]       state,
    output logic [1:0]       result,
    output logic             result_valid,
    output logic [TRY_W-1:0] tries_used,
    output logic [TRY_W-1:0] tries_left,
    output logic [W-1:0]     secret_out,
    output logic [W-1:0]     lo_bound,
    output logic [W-1:0]     hi_bound
);

    localparam logic [W-1:0]     SMAX = W'(SECRET_MAX);
    localparam logic [TRY_W-1:0] TMAX = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_cnt;
    logic [W-1:0]     r_secret;
    logic [W-1:0]     r_secret_out;
    logic [1:0]       r_result;
    logic             r_result_valid;
    logic [TRY_W-1:0] r_tries_used;
    logic [TRY_W-1:0] r_tries_left;

    logic             w_start;
    logic             w_accept;
    logic [TRY_W-1:0] w_budget;
    logic [W-1:0]     w_load_val;
    logic [1:0]       w_cmp;

    // Free-running secret source; keeps counting regardless of game state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_cnt >= SMAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // Event qualification, budget clamp, manual-secret clamp and comparison.
    always_comb begin
        w_start  = (r_state == ST_IDLE) && secret_load && !new_game;
        w_accept = (r_state == ST_PLAY) && guess_valid && !new_game;
        if ((tries_limit == '0) || (tries_limit > TMAX)) begin
            w_budget = TMAX;
        end else begin
            w_budget = tries_limit;
        end
        if (mode) begin
            w_load_val = r_cnt;
        end else if (value_in > SMAX) begin
            w_load_val = SMAX;
        end else begin
            w_load_val = value_in;
        end
        if (value_in < r_secret) begin
            w_cmp = 2'b01;
        end else if (value_in > r_secret) begin
            w_cmp = 2'b10;
        end else begin
            w_cmp = 2'b11;
        end
    end

    // Game state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; new_game overrides every other event.
    always_comb begin
        w_state_nxt = r_state;
        if (new_game) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (secret_load) begin
                        w_state_nxt = ST_PLAY;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_PLAY: begin
                    if (!guess_valid) begin
                        w_state_nxt = ST_PLAY;
                    end else if (w_cmp == 2'b11) begin
                        w_state_nxt = ST_WIN;
                    end else if (r_tries_left <= TRY_W'(1)) begin
                        w_state_nxt = ST_LOSE;
                    end else begin
                        w_state_nxt = ST_PLAY;
                    end
                end
                ST_WIN:  w_state_nxt = ST_WIN;
                ST_LOSE: w_state_nxt = ST_LOSE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Secret, result and attempt counters; tries_used + tries_left always equals the budget.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_secret       <= '0;
            r_secret_out   <= '0;
            r_result       <= 2'b00;
            r_result_valid <= 1'b0;
            r_tries_used   <= '0;
            r_tries_left   <= '0;
        end else begin
            r_result_valid <= 1'b0;
            if (new_game) begin
                r_result     <= 2'b00;
                r_tries_used <= '0;
                r_tries_left <= '0;
            end else if (w_start) begin
                r_secret     <= w_load_val;
                r_result     <= 2'b00;
                r_tries_used <= '0;
                r_tries_left <= w_budget;
            end else if (w_accept) begin
                r_result       <= w_cmp;
                r_result_valid <= 1'b1;
                if (r_tries_left != '0) begin
                    r_tries_used <= r_tries_used + TRY_W'(1);
                    r_tries_left <= r_tries_left - TRY_W'(1);
                end
            end
            // Secret is revealed in step with the state entering WIN/LOSE.
            if ((w_state_nxt == ST_WIN) || (w_state_nxt == ST_LOSE)) begin
                r_secret_out <= r_secret;
            end else begin
                r_secret_out <= '0;
            end
        end
    end

`ifdef RANGE_HINT_EN
    logic [W-1:0] r_lo;
    logic [W-1:0] r_hi;
    logic [W-1:0] w_g_inc;
    logic [W-1:0] w_g_dec;

    // A too-low guess is below the secret and a too-high one above zero, so neither overflows.
    always_comb begin
        w_g_inc = value_in + W'(1);
        w_g_dec = value_in - W'(1);
    end

    // Bound narrowing alongside the result update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lo <= '0;
            r_hi <= SMAX;
        end else if (new_game || w_start) begin
            r_lo <= '0;
            r_hi <= SMAX;
        end else if (w_accept) begin
            case (w_cmp)
                2'b01: begin
                    if (w_g_inc > r_lo) begin
                        r_lo <= w_g_inc;
                    end
                end
                2'b10: begin
                    if (w_g_dec < r_hi) begin
                        r_hi <= w_g_dec;
                    end
                end
                2'b11: begin
                    r_lo <= r_secret;
                    r_hi <= r_secret;
                end
                default: begin
                    r_lo <= r_lo;
                    r_hi <= r_hi;
                end
            endcase
        end
    end

    assign lo_bound = r_lo;
    assign hi_bound = r_hi;
`else
    assign lo_bound = '0;
    assign hi_bound = SMAX;
`endif

    assign state        = r_state;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign tries_used   = r_tries_used;
    assign tries_left   = r_tries_left;
    assign secret_out   = r_secret_out;

endmodule

// File: tb/tb_guess_engine.sv
// Scoreboard bench for guess_engine: a default instance for game flow and a SECRET_MAX=20 instance for the random counter.
module tb_guess_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b0, mode = 1'b0, secret_load = 1'b0, new_game = 1'b0, guess_valid = 1'b0;
    logic [16:0] value_in = 17'd0;
    logic [3:0]  tries_limit = 4'd0;
    logic [1:0]  state, result;
    logic        result_valid;
    logic [3:0]  tries_used, tries_left;
    logic [16:0] secret_out, lo_bound, hi_bound;

    logic        s_reset = 1'b0, s_mode = 1'b0, s_load = 1'b0, s_new = 1'b0, s_guess = 1'b0;
    logic [16:0] s_val = 17'd0;
    logic [3:0]  s_lim = 4'd0;
    logic [1:0]  s_state, s_result;
    logic        s_rv;
    logic [3:0]  s_tu, s_tl;
    logic [16:0] s_sout, s_lo, s_hi;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

`ifdef RANGE_HINT_EN
    localparam logic [16:0] EXP_LO_A = 17'd12345, EXP_HI_A = 17'd12345;
    localparam logic [16:0] EXP_LO_B = 17'd101,   EXP_HI_B = 17'd899;
`else
    localparam logic [16:0] EXP_LO_A = 17'd0,     EXP_HI_A = 17'd99999;
    localparam logic [16:0] EXP_LO_B = 17'd0,     EXP_HI_B = 17'd99999;
`endif

    guess_engine u_dut (
        .clk(clk), .reset(reset), .mode(mode), .secret_load(secret_load), .new_game(new_game),
        .guess_valid(guess_valid), .value_in(value_in), .tries_limit(tries_limit),
        .state(state), .result(result), .result_valid(result_valid), .tries_used(tries_used),
        .tries_left(tries_left), .secret_out(secret_out), .lo_bound(lo_bound), .hi_bound(hi_bound)
    );

    guess_engine #(.SECRET_MAX(20)) u_small (
        .clk(clk), .reset(s_reset), .mode(s_mode), .secret_load(s_load), .new_game(s_new),
        .guess_valid(s_guess), .value_in(s_val), .tries_limit(s_lim),
        .state(s_state), .result(s_result), .result_valid(s_rv), .tries_used(s_tu),
        .tries_left(s_tl), .secret_out(s_sout), .lo_bound(s_lo), .hi_bound(s_hi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result_valid: actual result=%0d tries_used=%0d required no pulse",
                         result, tries_used);
            end else begin
                chk("guess_resp{res,used,left,state}", {20'd0, result, tries_used, tries_left, state},
                    {20'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic load(input logic m, input logic [16:0] v, input logic [3:0] lim);
        @(negedge clk);
        mode = m; value_in = v; tries_limit = lim; secret_load = 1'b1;
        @(negedge clk);
        secret_load = 1'b0;
    endtask

    task automatic guess(input logic [16:0] v, input logic [1:0] r, input logic [3:0] tu,
                         input logic [3:0] tl, input logic [1:0] st);
        @(negedge clk);
        value_in = v; guess_valid = 1'b1;
        exp_q.push_back({r, tu, tl, st});
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic ignored_guess(input logic [16:0] v);
        @(negedge clk);
        value_in = v; guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic restart(input logic with_guess);
        @(negedge clk);
        new_game = 1'b1; guess_valid = with_guess; value_in = 17'd500;
        @(negedge clk);
        new_game = 1'b0; guess_valid = 1'b0;
    endtask

    task automatic small_guess(input logic [16:0] v);
        @(negedge clk);
        s_val = v; s_guess = 1'b1;
        @(negedge clk);
        s_guess = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state", state, 2'b00);
        chk("rst_result", result, 2'b00);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_used", tries_used, 4'd0);
        chk("rst_left", tries_left, 4'd0);
        chk("rst_secret", secret_out, 17'd0);
        chk("rst_lo", lo_bound, 17'd0);
        chk("rst_hi", hi_bound, 17'd99999);
        reset = 1'b1;

        // Manual game won on the third guess.
        load(1'b0, 17'd12345, 4'd3);
        chk("load_state", state, 2'b01);
        chk("load_left", tries_left, 4'd3);
        chk("play_secret_hidden", secret_out, 17'd0);
        guess(17'd100,   2'b01, 4'd1, 4'd2, 2'b01);
        guess(17'd20000, 2'b10, 4'd2, 4'd1, 2'b01);
        guess(17'd12345, 2'b11, 4'd3, 4'd0, 2'b10);
        chk("win_secret", secret_out, 17'd12345);
        chk("win_lo", lo_bound, EXP_LO_A);
        chk("win_hi", hi_bound, EXP_HI_A);
        ignored_guess(17'd1);
        chk("win_hold_state", state, 2'b10);
        chk("win_hold_used", tries_used, 4'd3);
        restart(1'b0);
        chk("ng_state", state, 2'b00);
        chk("ng_secret", secret_out, 17'd0);

        // Budget exhaustion.
        load(1'b0, 17'd7, 4'd2);
        guess(17'd1, 2'b01, 4'd1, 4'd1, 2'b01);
        guess(17'd9, 2'b10, 4'd2, 4'd0, 2'b11);
        chk("lose_secret", secret_out, 17'd7);
        ignored_guess(17'd7);
        chk("lose_hold_state", state, 2'b11);
        chk("lose_hold_used", tries_used, 4'd2);
        restart(1'b0);

        // Clamping of secret and budget; oversize guess counts as too high.
        load(1'b0, 17'd131071, 4'd0);
        chk("clamp_left", tries_left, 4'd15);
        guess(17'd131071, 2'b10, 4'd1, 4'd14, 2'b01);
        guess(17'd99999,  2'b11, 4'd2, 4'd13, 2'b10);
        chk("clamp_secret", secret_out, 17'd99999);
        restart(1'b0);

        // Range narrowing, then new_game beating a coincident guess.
        load(1'b0, 17'd500, 4'd5);
        guess(17'd100, 2'b01, 4'd1, 4'd4, 2'b01);
        guess(17'd900, 2'b10, 4'd2, 4'd3, 2'b01);
        chk("hint_lo", lo_bound, EXP_LO_B);
        chk("hint_hi", hi_bound, EXP_HI_B);
        restart(1'b1);
        chk("prio_state", state, 2'b00);
        chk("prio_used", tries_used, 4'd0);
        chk("prio_left", tries_left, 4'd0);
        chk("prio_lo", lo_bound, 17'd0);
        chk("prio_hi", hi_bound, 17'd99999);

        // secret_load during PLAY must not replace the secret.
        load(1'b0, 17'd500, 4'd5);
        load(1'b0, 17'd3, 4'd9);
        chk("reload_left", tries_left, 4'd5);
        guess(17'd500, 2'b11, 4'd1, 4'd4, 2'b10);
        restart(1'b0);

        // Asynchronous reset in the middle of a game.
        load(1'b0, 17'd42, 4'd0);
        guess(17'd1, 2'b01, 4'd1, 4'd14, 2'b01);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", state, 2'b00);
        chk("arst_result", result, 2'b00);
        chk("arst_valid", result_valid, 1'b0);
        chk("arst_used", tries_used, 4'd0);
        chk("arst_left", tries_left, 4'd0);
        @(negedge clk);
        reset = 1'b1;

        // Random secret: counter value k-1 is captured at the k-th edge after release.
        @(negedge clk);
        s_reset = 1'b1;
        repeat (5) @(negedge clk);
        s_mode = 1'b1; s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        small_guess(17'd5);
        chk("rand_state", s_state, 2'b10);
        chk("rand_secret", s_sout, 17'd5);

        // Load on the 22nd edge: the counter has wrapped from 20 to 0.
        @(negedge clk);
        s_reset = 1'b0;
        @(negedge clk);
        s_reset = 1'b1;
        repeat (21) @(negedge clk);
        s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        chk("wrap_left", s_tl, 4'd15);
        small_guess(17'd10);
        chk("wrap_high", s_result, 2'b10);
        small_guess(17'd0);
        chk("wrap_state", s_state, 2'b10);
        chk("wrap_secret", s_sout, 17'd0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
